lsu_wb: RTL and testbench

- Multi-cycle load/store unit sitting directly upstream of the register-file write port.
- Accepts one memory op from the core and runs a valid/ready request and response transaction on the data bus.
- Aligns and sign-extends load data, then drives the register-file write port (we/wa/wd) for one cycle.
- Stalls the core via busy until the op completes.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_load_align.sv | 48 ++++
 rtl/lsu_wb.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_wb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 width codes, store-strobe base patterns and legality helpers.
// Optional build macro: LSU_MISALIGN_TRAP_EN (used by addr_misaligned()
// callers in lsu_wb).
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Stores only know signed widths; loads add the two unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return (lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data extraction: selects the addressed byte/half of the
// read word and sign- or zero-extends it according to funct3.
// Ports:
//   i_rdata    32-bit word returned by the data bus
//   i_addr_lo  byte offset within the word (addr[1:0])
//   i_funct3   RV32I load width/sign code
//   o_data     extended 32-bit result for the register file
// ---------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase

        // Half select uses addr[1] only; addr[0] is ignored here.
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lsu_wb
// Multi-cycle load/store unit feeding the register-file write port.
// Takes one op from the core, runs a valid/ready request (and, for loads, a
// rvalid response) on the data bus, then pulses req_ack for one cycle and,
// for loads with rd!=0, writes the aligned/extended data to the register file.
// busy is high whenever the FSM is not IDLE.
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   req_*                       core op (valid, we, funct3, addr, wdata, rd)
//   req_ack, busy, misalign     completion pulse, stall, misalign flag
//   mem_valid/ready/we/addr/wstrb/wdata   bus request channel
//   mem_rvalid/rdata            bus read response
//   rf_we/wa/wd                 register-file write port
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned half/word accesses
// skip the bus and complete with misalign=1. Undefined: misalign tied 0 and
// low address bits are ignored.
// ---------------------------------------------------------------------------
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              req_ack,
    output logic              busy,
    output logic              misalign,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [31:0]       rf_wd
);

    state_t            r_state;
    state_t            w_next;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [4:0]        r_rd;
    logic [31:0]       r_rdata;
    logic              r_skip;     // op completes without touching the bus

    logic              w_accept;
    logic              w_req_skip;
    logic [3:0]        w_strb;
    logic [31:0]       w_store_data;
    logic [31:0]       w_load_data;

`ifdef LSU_MISALIGN_TRAP_EN
    logic              r_misal;
    logic              w_req_misal;

    assign w_req_misal = addr_misaligned(req_funct3, req_addr[1:0]);
    assign w_req_skip  = !f3_legal(req_we, req_funct3) || w_req_misal;
`else
    assign w_req_skip  = !f3_legal(req_we, req_funct3);
`endif

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: the captured op and read data are plain registers (not an array),
    // so they are cleared on reset to make every output 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rd     <= 5'd0;
            r_rdata  <= 32'd0;
            r_skip   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misal  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_rd     <= req_rd;
                r_skip   <= w_req_skip;
`ifdef LSU_MISALIGN_TRAP_EN
                r_misal  <= w_req_misal;
`endif
            end
            // rvalid is only honoured in RESP, so a stray response after a
            // reset or during REQ can never corrupt the captured data.
            if ((r_state == ST_RESP) && mem_rvalid) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Store lane placement: data is replicated so the strobes pick the lane.
    always_comb begin
        w_strb       = STRB_W;
        w_store_data = r_wdata;
        case (r_funct3)
            F3_B: begin
                w_strb       = STRB_B << r_addr[1:0];
                w_store_data = {4{r_wdata[7:0]}};
            end
            F3_H: begin
                w_strb       = STRB_H << {r_addr[1], 1'b0};
                w_store_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_strb       = STRB_W;
                w_store_data = r_wdata;
            end
        endcase
    end

    lsu_load_align u_align (
        .i_rdata   (r_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_next    = r_state;
        req_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        rf_we     = 1'b0;
        rf_wa     = 5'd0;
        rf_wd     = 32'd0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = w_req_skip ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_valid = 1'b1;
                mem_we    = r_we;
                mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
                if (r_we) begin
                    mem_wstrb = w_strb;
                    mem_wdata = w_store_data;
                end
                if (mem_ready) begin
                    w_next = r_we ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                req_ack = 1'b1;
                rf_we   = !r_we && !r_skip && (r_rd != 5'd0);
                rf_wa   = r_rd;
                rf_wd   = w_load_data;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (r_state == ST_DONE) && r_misal;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_wb.sv
`timescale 1ns/1ps
module tb_lsu_wb;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        req_ack, busy, misalign;
    logic        mem_valid, mem_we;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    always #5 clk = ~clk;

    lsu_wb #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .req_ack    (req_ack),
        .busy       (busy),
        .misalign   (misalign),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          rdy_dly;
        int          rsp_dly;
        logic        exp_bus;
        logic [3:0]  exp_strb;
        logic [31:0] exp_mdata;
        logic        exp_rf_we;
        logic [31:0] exp_rf_wd;
        logic        exp_mis;
        int          exp_lat;   // cycle of req_ack, req_valid first sampled = cycle 1
    } vec_t;

    function automatic vec_t mk(
        input logic we, input logic [2:0] f3, input logic [31:0] addr,
        input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
        input int rdy, input int rsp, input logic bus, input logic [3:0] strb,
        input logic [31:0] mdata, input logic rfwe, input logic [31:0] rfwd,
        input logic mis, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rd = rd; v.rdy_dly = rdy; v.rsp_dly = rsp; v.exp_bus = bus;
        v.exp_strb = strb; v.exp_mdata = mdata; v.exp_rf_we = rfwe;
        v.exp_rf_wd = rfwd; v.exp_mis = mis; v.exp_lat = lat;
        return v;
    endfunction

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic run_op(input int id, input vec_t v);
        int          cyc, lat, wait_cnt, rsp_cnt;
        logic        got_ack, hs_pend, in_resp, saw_bus;
        logic        unstable, busy_drop, stray_rfwe, mv_in_resp;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic        w0;
        logic        k_rfwe, k_mis;
        logic [4:0]  k_wa;
        logic [31:0] k_wd;

        cyc = 0; lat = 0; wait_cnt = 0; rsp_cnt = 0;
        got_ack = 0; hs_pend = 0; in_resp = 0; saw_bus = 0;
        unstable = 0; busy_drop = 0; stray_rfwe = 0; mv_in_resp = 0;
        a0 = 0; d0 = 0; s0 = 0; w0 = 0;
        k_rfwe = 0; k_mis = 0; k_wa = 0; k_wd = 0;

        @(negedge clk);
        req_we = v.we; req_funct3 = v.f3; req_addr = v.addr;
        req_wdata = v.wdata; req_rd = v.rd; req_valid = 1'b1;

        while (!got_ack && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            if (hs_pend && !v.we) begin
                in_resp = 1'b1;
                rsp_cnt = 0;
            end
            hs_pend = 1'b0;
            if (req_ack) begin
                got_ack = 1'b1;
                lat = cyc + 1;
                k_rfwe = rf_we; k_wa = rf_wa; k_wd = rf_wd; k_mis = misalign;
                req_valid = 1'b0;
            end else begin
                if (!busy) busy_drop = 1'b1;
                if (rf_we) stray_rfwe = 1'b1;
                if (in_resp && mem_valid) mv_in_resp = 1'b1;
                if (mem_valid && !in_resp) begin
                    if (!saw_bus) begin
                        saw_bus = 1'b1;
                        a0 = mem_addr; d0 = mem_wdata; s0 = mem_wstrb; w0 = mem_we;
                    end else if (mem_addr !== a0 || mem_wdata !== d0 ||
                                 mem_wstrb !== s0 || mem_we !== w0) begin
                        unstable = 1'b1;
                    end
                    if (wait_cnt >= v.rdy_dly) begin
                        mem_ready = 1'b1;
                        hs_pend = 1'b1;
                    end
                    wait_cnt++;
                end else if (in_resp) begin
                    if (rsp_cnt >= v.rsp_dly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                        in_resp    = 1'b0;
                    end
                    rsp_cnt++;
                end
            end
        end
        req_valid = 1'b0;

        check($sformatf("v%0d ack_cycle", id), lat, v.exp_lat);
        check($sformatf("v%0d bus_seen", id), {31'd0, saw_bus}, {31'd0, v.exp_bus});
        if (v.exp_bus) begin
            check($sformatf("v%0d mem_addr", id), a0, {v.addr[31:2], 2'b00});
            check($sformatf("v%0d mem_we", id), {31'd0, w0}, {31'd0, v.we});
            if (v.we) begin
                check($sformatf("v%0d mem_wstrb", id), {28'd0, s0}, {28'd0, v.exp_strb});
                check($sformatf("v%0d mem_wdata", id), d0, v.exp_mdata);
            end
        end
        check($sformatf("v%0d protocol(busy_drop,stray_rfwe,mv_in_resp,unstable)", id),
              {28'd0, busy_drop, stray_rfwe, mv_in_resp, unstable}, 32'd0);
        check($sformatf("v%0d rf_we", id), {31'd0, k_rfwe}, {31'd0, v.exp_rf_we});
        if (v.exp_rf_we) begin
            check($sformatf("v%0d rf_wa", id), {27'd0, k_wa}, {27'd0, v.rd});
            check($sformatf("v%0d rf_wd", id), k_wd, v.exp_rf_wd);
        end
        check($sformatf("v%0d misalign", id), {31'd0, k_mis}, {31'd0, v.exp_mis});

        // One cycle after the ack the unit must be idle again.
        @(posedge clk);
        #1;
        check($sformatf("v%0d idle_after(busy,ack,rf_we)", id),
              {29'd0, busy, req_ack, rf_we}, 32'd0);
    endtask

    initial begin
        logic [31:0] acc;

        // {we, f3, addr, wdata, rdata, rd, rdy, rsp, bus, strb, mdata, rf_we, rf_wd, mis, lat}
        vecs[0]  = mk(0, F3_W,   32'h100, 32'h0,        32'hDEADBEEF, 5, 0, 0, 1, 4'b0000, 32'h0,        1, 32'hDEADBEEF, 0, 4);
        vecs[1]  = mk(0, F3_B,   32'h103, 32'h0,        32'h80FF7F01, 7, 0, 0, 1, 4'b0000, 32'h0,        1, 32'hFFFFFF80, 0, 4);
        vecs[2]  = mk(0, F3_BU,  32'h103, 32'h0,        32'h80FF7F01, 7, 0, 0, 1, 4'b0000, 32'h0,        1, 32'h00000080, 0, 4);
        vecs[3]  = mk(1, F3_H,   32'h202, 32'h1234ABCD, 32'h0,        1, 3, 0, 1, 4'b1100, 32'hABCDABCD, 0, 32'h0,        0, 6);
        vecs[4]  = mk(0, F3_W,   32'h104, 32'h0,        32'h13579BDF, 0, 0, 0, 1, 4'b0000, 32'h0,        0, 32'h0,        0, 4);
        vecs[5]  = mk(0, 3'b110, 32'h108, 32'h0,        32'h0,        4, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 2);
        vecs[6]  = mk(1, F3_B,   32'h101, 32'h000000A5, 32'h0,        1, 1, 0, 1, 4'b0010, 32'hA5A5A5A5, 0, 32'h0,        0, 4);
        vecs[7]  = mk(1, F3_W,   32'h300, 32'h11223344, 32'h0,        1, 0, 0, 1, 4'b1111, 32'h11223344, 0, 32'h0,        0, 3);
        vecs[8]  = mk(0, F3_H,   32'h102, 32'h0,        32'h80011234, 3, 0, 0, 1, 4'b0000, 32'h0,        1, 32'hFFFF8001, 0, 4);
        vecs[9]  = mk(0, F3_HU,  32'h102, 32'h0,        32'h80011234, 3, 0, 0, 1, 4'b0000, 32'h0,        1, 32'h00008001, 0, 4);
        vecs[10] = mk(0, F3_H,   32'h100, 32'h0,        32'h80011234, 3, 0, 0, 1, 4'b0000, 32'h0,        1, 32'h00001234, 0, 4);
        vecs[11] = mk(1, 3'b011, 32'h10C, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = mk(0, F3_W,   32'h101, 32'h0,        32'hCAFEF00D, 9, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, 2);
`else
        vecs[12] = mk(0, F3_W,   32'h101, 32'h0,        32'hCAFEF00D, 9, 0, 0, 1, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 0, 4);
`endif
        vecs[13] = mk(0, F3_B,   32'h102, 32'h0,        32'h80FF7F01, 8, 0, 2, 1, 4'b0000, 32'h0,        1, 32'hFFFFFFFF, 0, 6);

        // Reset state
        #12;
        check("reset ctl(ack,busy,mis,mvalid,mwe,wstrb,rfwe)",
              {22'd0, req_ack, busy, misalign, mem_valid, mem_we, mem_wstrb, rf_we}, 32'd0);
        check("reset data(addr|wdata|rf_wd|rf_wa)",
              mem_addr | mem_wdata | rf_wd | {27'd0, rf_wa}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(i, vecs[i]);
        end

        // Reset asserted while the unit waits in RESP; a late rvalid must be ignored.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h400; req_rd = 5'd6;
        req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;          // now in REQ
        check("rst_seq in_req", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        @(posedge clk); #1;          // now in RESP
        mem_ready = 1'b0;
        check("rst_seq in_resp(busy,mvalid)", {30'd0, busy, mem_valid}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        req_valid = 1'b0;
        check("rst_seq ctl zero",
              {22'd0, req_ack, busy, misalign, mem_valid, mem_we, mem_wstrb, rf_we}, 32'd0);
        check("rst_seq data zero",
              mem_addr | mem_wdata | rf_wd | {27'd0, rf_wa}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFEEDFACE;
        acc = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            acc = acc | {29'd0, busy, req_ack, rf_we};
        end
        check("rst_seq late rvalid ignored(busy,ack,rf_we)", acc, 32'd0);

        // Unit must still work normally after the abandoned op.
        run_op(100, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
